ram_block_mover: RTL and testbench
==================================

Name: ram_block_mover

Overview:
- Command-driven initiator that drives both ports of the testbench dual-port RAM model.
- Copies a block of words from a source range to a destination range, or fills a range with a pattern.
- Port A is used only for reads (one-cycle read latency); port B is used only for full-word writes.
- Used by corev_apu testbenches to preload, clear and relocate memory images without backdoor access.

Parameters:
- ADDR_WIDTH, 8, word-address width of the attached RAM.
- DATA_WIDTH, 64, word width in bits; multiple of 8.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accept; high only when idle.
- cmd_fill_i  in  1  1 = fill with pattern, 0 = copy.
- cmd_src_i  in  ADDR_WIDTH  copy source start word address.
- cmd_dst_i  in  ADDR_WIDTH  destination start word address.
- cmd_len_i  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
- cmd_pattern_i  in  DATA_WIDTH  fill data.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle completion pulse.
- en_a_o, addr_a_o[ADDR_WIDTH], wdata_a_o[DATA_WIDTH], we_a_o, be_a_o[DATA_WIDTH/8]  out  RAM port A request.
- rdata_a_i  in  DATA_WIDTH  port A read data, valid the cycle after en_a_o.
- en_b_o, addr_b_o[ADDR_WIDTH], wdata_b_o[DATA_WIDTH], we_b_o, be_b_o[DATA_WIDTH/8]  out  RAM port B request.
- rdata_b_i  in  DATA_WIDTH  unused.

Behaviour:
- Reset values: cmd_ready_o=1; all other outputs 0. Reset is asynchronous and active-low; asserting it mid-command aborts immediately with no further RAM accesses, no done_o, and a return to IDLE.
- States:
  - IDLE: cmd_ready_o=1.
  - COPY: issue reads.
  - DRAIN: final copy write.
  - FILL: issue writes.
- Constant tie-offs: we_a_o=0, wdata_a_o=0, be_a_o=0 always. When en_b_o=1: we_b_o=1 and be_b_o=all ones. When en_b_o=0: we_b_o=0 and be_b_o=0.
- Accept: on cmd_valid_i & cmd_ready_o; all cmd_* fields are latched. Command inputs are ignored while busy_o=1. busy_o = state != IDLE.
- Address arithmetic: all address arithmetic is modulo 2^ADDR_WIDTH; ranges wrap past the top word to 0.
- len=0: no RAM access. done_o=1 in the cycle after acceptance; state stays IDLE.
- Copy direction: descending when dst!=src and ((dst-src) mod 2^AW) < len; otherwise ascending.
  - Descending starts at src+len-1 / dst+len-1 and decrements.
  - This guarantees a read never targets a word already overwritten, given the RAM's read-old-data on same-cycle collisions.
- Copy timing (acceptance edge = cycle 0, N=len):
  - Cycles 1..N: en_a_o=1, addr_a_o = next source address.
  - Cycles 2..N+1: en_b_o=1, addr_b_o = matching destination address, wdata_b_o = rdata_a_i. Cycle N+1 is DRAIN.
  - Cycle N+2: done_o=1, state IDLE, cmd_ready_o=1.
  - Throughput is one word per cycle, no bubbles.
- Fill timing:
  - Cycles 1..N: en_b_o=1, ascending from dst, wdata_b_o = pattern.
  - Cycle N+1: done_o=1, IDLE.
  - Port A stays idle.
- No combinational path from cmd_* inputs to any RAM-port output.
- Back-to-back: a new command may be accepted in the cycle done_o is high. The next command's first access occurs in the cycle after that acceptance.
- len=2^AW copy with dst!=src: access sequence follows the descending rule. Resulting contents are not a meaningful copy and are not checked.

Test Plan:
- Copy, AW=8: src=0x10, dst=0x80, len=4, source words A,B,C,D -> port A reads 0x10..0x13 in cycles 1-4; port B writes 0x80..0x83 = A..D in cycles 2-5; done_o in cycle 6.
- Forward overlap: src=0x20, dst=0x22, len=4, words 1,2,3,4 -> descending; reads 0x23..0x20; mem[0x22..0x25]=1,2,3,4.
- Backward overlap: src=0x22, dst=0x20, len=4 -> ascending; mem[0x20..0x23] = original 0x22..0x25 contents.
- Fill wrap: dst=0xFE, len=4, pattern=0xDEADBEEF_CAFEF00D -> writes to 0xFE, 0xFF, 0x00, 0x01 with be all ones; port A en never set; done_o in cycle 5.
- Edge lengths: len=0 -> no en_a_o/en_b_o, done_o in cycle 1. Fill with len=256 -> all 256 words written, done_o in cycle 257.
- Reset and back-to-back:
  - Copy len=16 with rst_ni low at cycle 5 -> all outputs 0 immediately, no done_o, cmd_ready_o=1 after release.
  - Second command presented during done_o -> accepted; next first access in the following cycle.

Source files
------------

// File: rtl/ram_block_mover.sv
// rtl/ram_block_mover.sv - command-driven block copy / pattern fill initiator for a dual-port RAM
module ram_block_mover #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_fill_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_src_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_dst_i,
  input  logic [ADDR_WIDTH:0]     cmd_len_i,
  input  logic [DATA_WIDTH-1:0]   cmd_pattern_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    en_a_o,
  output logic [ADDR_WIDTH-1:0]   addr_a_o,
  output logic [DATA_WIDTH-1:0]   wdata_a_o,
  output logic                    we_a_o,
  output logic [DATA_WIDTH/8-1:0] be_a_o,
  input  logic [DATA_WIDTH-1:0]   rdata_a_i,
  output logic                    en_b_o,
  output logic [ADDR_WIDTH-1:0]   addr_b_o,
  output logic [DATA_WIDTH-1:0]   wdata_b_o,
  output logic                    we_b_o,
  output logic [DATA_WIDTH/8-1:0] be_b_o,
  input  logic [DATA_WIDTH-1:0]   rdata_b_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2,
    FILL  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [ADDR_WIDTH:0]     cnt_q;
  logic                    desc_q;
  logic                    wr_pend_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   pattern_q;

  logic                    accept;
  logic                    len_zero;
  logic                    dir_desc;
  logic [ADDR_WIDTH-1:0]   addr_diff;
  logic [ADDR_WIDTH-1:0]   len_low;
  logic [ADDR_WIDTH-1:0]   src_start;
  logic [ADDR_WIDTH-1:0]   dst_start;
  logic [ADDR_WIDTH-1:0]   rd_addr_next;
  logic [ADDR_WIDTH-1:0]   wr_addr_next;

  // Port B read data is never consumed; fold it into a sink so it is visibly unused.
  logic unused_rdata_b;
  assign unused_rdata_b = ^rdata_b_i;

  assign accept   = cmd_valid_i && (state_q == IDLE);
  assign len_zero = (cmd_len_i == '0);

  // Pick copy direction and start addresses so a read never hits a word already overwritten.
  always_comb begin
    addr_diff = cmd_dst_i - cmd_src_i;
    len_low   = cmd_len_i[ADDR_WIDTH-1:0];
    dir_desc  = (cmd_dst_i != cmd_src_i) && ({1'b0, addr_diff} < cmd_len_i);
    src_start = cmd_src_i;
    dst_start = cmd_dst_i;
    if (dir_desc && !cmd_fill_i) begin
      src_start = cmd_src_i + len_low - ADDR_ONE;
      dst_start = cmd_dst_i + len_low - ADDR_ONE;
    end
  end

  // Address stepping follows the latched direction; fills always ascend (desc_q cleared).
  always_comb begin
    rd_addr_next = desc_q ? (rd_addr_q - ADDR_ONE) : (rd_addr_q + ADDR_ONE);
    wr_addr_next = desc_q ? (wr_addr_q - ADDR_ONE) : (wr_addr_q + ADDR_ONE);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and RAM-port controls; outputs depend only on registered state.
  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    en_a_o      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (accept && !len_zero) begin
          state_d = cmd_fill_i ? FILL : COPY;
        end
      end
      COPY: begin
        en_a_o = 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      FILL: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    en_b_o = (state_q == FILL) || wr_pend_q;
  end

  // Command latch, address/count walkers, one-cycle write pipeline and done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      desc_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      done_q    <= 1'b0;
      pattern_q <= '0;
    end else begin
      wr_pend_q <= (state_q == COPY);
      done_q    <= (accept && len_zero) ||
                   (state_q == DRAIN) ||
                   ((state_q == FILL) && (cnt_q == CNT_ONE));
      if (accept) begin
        rd_addr_q <= src_start;
        wr_addr_q <= dst_start;
        cnt_q     <= cmd_len_i;
        desc_q    <= dir_desc && !cmd_fill_i;
        pattern_q <= cmd_pattern_i;
      end else begin
        if (state_q == COPY) begin
          rd_addr_q <= rd_addr_next;
          cnt_q     <= cnt_q - CNT_ONE;
        end
        if (state_q == FILL) begin
          cnt_q <= cnt_q - CNT_ONE;
        end
        if (en_b_o) begin
          wr_addr_q <= wr_addr_next;
        end
      end
    end
  end

  assign done_o    = done_q;

  // Port A is read-only; port B is full-word write-only.
  assign addr_a_o  = en_a_o ? rd_addr_q : '0;
  assign wdata_a_o = '0;
  assign we_a_o    = 1'b0;
  assign be_a_o    = '0;

  assign addr_b_o  = en_b_o ? wr_addr_q : '0;
  assign wdata_b_o = !en_b_o ? '0 : ((state_q == FILL) ? pattern_q : rdata_a_i);
  assign we_b_o    = en_b_o;
  assign be_b_o    = en_b_o ? {BE_WIDTH{1'b1}} : '0;

endmodule

// File: tb/tb_ram_block_mover.sv
// tb/tb_ram_block_mover.sv - scoreboard bench for ram_block_mover with a dual-port RAM model
module tb_ram_block_mover;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_fill = 1'b0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [AW:0]   cmd_len = '0;
  logic [DW-1:0] cmd_pattern = '0;
  logic          busy, done;
  logic          en_a, we_a, en_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b;
  logic [BW-1:0] be_a, be_b;

  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] shadow [0:255];
  logic          init_req = 1'b0;
  logic          poke_en = 1'b0;
  logic [7:0]    poke_addr = '0;
  logic [63:0]   poke_data = '0;

  exp_t rq[$];
  exp_t wq[$];
  int   dq[$];
  int   cyc = 0;
  int   last_c0 = 0;
  int   vectors = 0;
  int   miscompares = 0;

  ram_block_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_fill_i(cmd_fill),
    .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len), .cmd_pattern_i(cmd_pattern),
    .busy_o(busy), .done_o(done),
    .en_a_o(en_a), .addr_a_o(addr_a), .wdata_a_o(wdata_a), .we_a_o(we_a), .be_a_o(be_a),
    .rdata_a_i(rdata_a),
    .en_b_o(en_b), .addr_b_o(addr_b), .wdata_b_o(wdata_b), .we_b_o(we_b), .be_b_o(be_b),
    .rdata_b_i(rdata_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rdata_b = '0;

  function automatic logic [63:0] init_word(input int i);
    return {32'hA0A0_0000 | 32'(i), 32'h0000_5A5A ^ 32'(i)};
  endfunction

  function automatic logic [127:0] pk(input int c, input logic [7:0] a, input logic [63:0] d);
    return {24'd0, 32'(c), a, d};
  endfunction

  // RAM model: read-old-data on collisions, byte-enabled writes on port B.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      if (poke_en) mem[poke_addr] <= poke_data;
      if (en_a) rdata_a <= mem[addr_a];
      if (en_b && we_b) begin
        for (int b = 0; b < BW; b++)
          if (be_b[b]) mem[addr_b][b*8 +: 8] <= wdata_b[b*8 +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows RAM activity or done.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("port_ties", 128'({we_a, be_a, wdata_a, we_b, be_b}),
            128'({1'b0, 8'h00, 64'h0, en_b, en_b ? 8'hFF : 8'h00}));
      if (en_a) begin
        if (rq.size() == 0) check("unexpected_read", pk(cyc, addr_a, 64'h0), 128'h0);
        else begin
          e = rq.pop_front();
          check("read", pk(cyc, addr_a, 64'h0), pk(e.cyc, e.addr, 64'h0));
        end
      end
      if (en_b) begin
        if (wq.size() == 0) check("unexpected_write", pk(cyc, addr_b, wdata_b), 128'h0);
        else begin
          e = wq.pop_front();
          check("write", pk(cyc, addr_b, wdata_b), pk(e.cyc, e.addr, e.data));
        end
      end
      if (done) begin
        if (dq.size() == 0) check("unexpected_done", 128'(cyc), 128'h0);
        else check("done_cycle", 128'(cyc), 128'(dq.pop_front()));
      end
    end
  end

  // Expected access stream; entries at or beyond 'cut' are never produced (aborted command).
  task automatic push_model(input logic fill, input logic [7:0] src, input logic [7:0] dst,
                            input logic [8:0] len, input logic [63:0] pat, input int c0, input int cut);
    logic [63:0] snap [0:255];
    logic [7:0]  r, w, ln;
    logic        desc;
    int          n;
    n = int'(len);
    ln = len[7:0];
    for (int i = 0; i < 256; i++) snap[i] = shadow[i];
    if (fill) begin
      for (int k = 0; k < n; k++) begin
        w = dst + 8'(k);
        if (c0 + k < cut) begin
          wq.push_back('{cyc: c0 + k, addr: w, data: pat});
          shadow[w] = pat;
        end
      end
      if (c0 + n < cut) dq.push_back(c0 + n);
    end else begin
      desc = (dst != src) && ({1'b0, 8'(dst - src)} < len);
      for (int k = 0; k < n; k++) begin
        r = desc ? 8'(src + ln - 8'd1 - 8'(k)) : 8'(src + 8'(k));
        w = desc ? 8'(dst + ln - 8'd1 - 8'(k)) : 8'(dst + 8'(k));
        if (c0 + k < cut) rq.push_back('{cyc: c0 + k, addr: r, data: 64'h0});
        if (c0 + 1 + k < cut) begin
          wq.push_back('{cyc: c0 + 1 + k, addr: w, data: snap[r]});
          shadow[w] = snap[r];
        end
      end
      if (n == 0) begin
        if (c0 < cut) dq.push_back(c0);
      end else if (c0 + n + 1 < cut) dq.push_back(c0 + n + 1);
    end
  endtask

  task automatic issue(input logic fill, input logic [7:0] src, input logic [7:0] dst,
                       input logic [8:0] len, input logic [63:0] pat, input int cut);
    int guard = 0;
    cmd_fill = fill; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_pattern = pat;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("issue_timeout", 128'(guard), 128'h0);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_src = 8'h33; cmd_dst = 8'h44; cmd_len = 9'd7; cmd_pattern = '1;
    last_c0 = cyc;
    push_model(fill, src, dst, len, pat, last_c0, 32'h7FFF_FFFF);
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while ((busy || rq.size() != 0 || wq.size() != 0 || dq.size() != 0) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 600) begin
      check("idle_timeout", 128'({rq.size(), wq.size(), dq.size()}), 128'h0);
      rq.delete(); wq.delete(); dq.delete();
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [63:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
    shadow[a] = d;
  endtask

  initial begin
    int bad;
    int done_cyc;
    logic [63:0] p_fill, p_b2b, p_all;
    p_fill = 64'hDEADBEEF_CAFEF00D;
    p_b2b  = 64'h0123_4567_89AB_CDEF;
    p_all  = 64'h5555_AAAA_5555_AAAA;

    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    check("reset_ready_busy_done", 128'({cmd_ready, busy, done}), 128'(3'b100));
    check("reset_port_a", 128'({en_a, addr_a, wdata_a, we_a, be_a}), 128'h0);
    check("reset_port_b", 128'({en_b, addr_b, wdata_b, we_b, be_b}), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain copy 0x10..0x13 -> 0x80..0x83.
    issue(1'b0, 8'h10, 8'h80, 9'd4, 64'h0, 0);
    check("busy_during_copy", 128'({busy, cmd_ready}), 128'(2'b10));
    wait_idle();
    check("copy_mem_80", 128'(mem[8'h80]), 128'(64'hA0A00010_00005A4A));
    check("copy_mem_83", 128'(mem[8'h83]), 128'(64'hA0A00013_00005A49));

    // Forward overlap: must run descending.
    for (int i = 0; i < 4; i++) poke(8'h20 + 8'(i), 64'(i + 1));
    issue(1'b0, 8'h20, 8'h22, 9'd4, 64'h0, 0);
    wait_idle();
    for (int i = 0; i < 4; i++) check("fwd_overlap_mem", 128'(mem[8'h22 + 8'(i)]), 128'(i + 1));

    // Backward overlap: ascending, 0x22..0x25 (now 1..4) -> 0x20..0x23.
    issue(1'b0, 8'h22, 8'h20, 9'd4, 64'h0, 0);
    wait_idle();
    for (int i = 0; i < 4; i++) check("bwd_overlap_mem", 128'(mem[8'h20 + 8'(i)]), 128'(i + 1));

    // Fill wrapping past the top word.
    issue(1'b1, 8'h00, 8'hFE, 9'd4, p_fill, 0);
    wait_idle();
    check("fill_wrap_fe", 128'(mem[8'hFE]), 128'(p_fill));
    check("fill_wrap_01", 128'(mem[8'h01]), 128'(p_fill));
    check("fill_wrap_02_untouched", 128'(mem[8'h02]), 128'(64'hA0A00002_00005A58));
    check("fill_wrap_fd_untouched", 128'(mem[8'hFD]), 128'(64'hA0A000FD_00005AA7));

    // Zero-length copy and fill: done only.
    issue(1'b0, 8'h05, 8'h90, 9'd0, 64'h0, 0);
    wait_idle();
    issue(1'b1, 8'h00, 8'h90, 9'd0, p_fill, 0);
    wait_idle();
    check("len0_untouched", 128'(mem[8'h90]), 128'(64'hA0A00090_00005ACA));

    // Back-to-back: second command presented while done is high.
    issue(1'b1, 8'h00, 8'h50, 9'd2, p_b2b, 0);
    bad = 0;
    while (!done && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    check("b2b_done_seen", 128'(done), 128'(1'b1));
    done_cyc = cyc;
    issue(1'b0, 8'h50, 8'h60, 9'd2, 64'h0, 0);
    check("b2b_accept_cycle", 128'(last_c0), 128'(done_cyc + 1));
    wait_idle();
    check("b2b_mem_60", 128'(mem[8'h60]), 128'(p_b2b));
    check("b2b_mem_61", 128'(mem[8'h61]), 128'(p_b2b));

    // Abort a 16-word copy with reset during cycle 5.
    cmd_fill = 1'b0; cmd_src = 8'h40; cmd_dst = 8'hC0; cmd_len = 9'd16; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    last_c0 = cyc;
    push_model(1'b0, 8'h40, 8'hC0, 9'd16, 64'h0, last_c0, last_c0 + 4);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 128'({busy, done, en_a, en_b, we_b, be_b, addr_a, addr_b}), 128'h0);
    check("abort_wdata_b", 128'(wdata_b), 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready_after_release", 128'({cmd_ready, busy}), 128'(2'b10));
    check("abort_queues_drained", 128'({rq.size(), wq.size(), dq.size()}), 128'h0);
    repeat (3) @(negedge clk);
    check("abort_c2_written", 128'(mem[8'hC2]), 128'(64'hA0A00042_00005A18));
    check("abort_c3_untouched", 128'(mem[8'hC3]), 128'(64'hA0A000C3_00005A99));
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) bad++;
    check("mem_image", 128'(bad), 128'h0);

    // Full-range fill.
    issue(1'b1, 8'h00, 8'h37, 9'd256, p_all, 0);
    wait_idle();
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== p_all) bad++;
    check("fill256_all_words", 128'(bad), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
